// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner
//   Time-multiplexes a two-digit BCD value onto one shared 7-segment bus.
//   The digits are snapshotted once per frame so a frame never mixes old and new
//   values. The block also provides leading-zero blanking, PWM brightness control
//   and a sticky flag for snapshots that hold a non-BCD digit.
//
// Ports
//   clk         clock, all state on the rising edge
//   rst         synchronous active-high reset
//   digit1      tens digit (BCD)
//   digit0      ones digit (BCD)
//   blank_lz    1: hide the tens digit when its snapshot is 0
//   brightness  PWM duty control: 0 = dark, all ones = full on
//   err_clr     clears err
//   seg         segments {g,f,e,d,c,b,a}, registered, polarity per SEG_ACTIVE_LOW
//   dig_en      one-hot digit enable ([0] ones, [1] tens), polarity per DIG_ACTIVE_LOW
//   err         sticky: a snapshot captured a digit greater than 9
module bcd_display_scanner #(
  parameter int unsigned REFRESH_DIV    = 1000,
  parameter int unsigned PWM_BITS       = 3,
  parameter int unsigned SEG_ACTIVE_LOW = 0,
  parameter int unsigned DIG_ACTIVE_LOW = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          digit1,
  input  logic [3:0]          digit0,
  input  logic                blank_lz,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic                err_clr,
  output logic [6:0]          seg,
  output logic [1:0]          dig_en,
  output logic                err
);

  localparam int unsigned     RefW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RefW-1:0] RefLast = RefW'(REFRESH_DIV - 1);
  // XOR masks double as the off level, since off is "nothing lit" before inversion.
  localparam logic [6:0]      SegInv  = (SEG_ACTIVE_LOW != 0) ? 7'h7f : 7'h00;
  localparam logic [1:0]      DigInv  = (DIG_ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

  logic [RefW-1:0]     ref_cnt_q, ref_cnt_d;
  logic                slot_q, slot_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [3:0]          shadow_tens_q, shadow_tens_d;
  logic [3:0]          shadow_ones_q, shadow_ones_d;
  logic                err_q, err_d;
  logic [6:0]          seg_q, seg_d;
  logic [1:0]          dig_en_q, dig_en_d;

  logic                ref_wrap;
  logic                frame_end;
  logic                pwm_on;
  logic                tens_blank;
  logic                sel_en;
  logic                digit_bad;
  logic [3:0]          cur_digit;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3f;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5b;
      4'd3:    s = 7'h4f;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6d;
      4'd6:    s = 7'h7d;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7f;
      4'd9:    s = 7'h6f;
      default: s = 7'h40;  // non-BCD shows a dash
    endcase
    return s;
  endfunction

  always_comb begin
    ref_wrap   = (ref_cnt_q == RefLast);
    // Last cycle of the tens slot: the next cycle starts a new frame.
    frame_end  = ref_wrap && slot_q;
    pwm_on     = (brightness == '1) || (pwm_cnt_q < brightness);
    cur_digit  = slot_q ? shadow_tens_q : shadow_ones_q;
    tens_blank = slot_q && blank_lz && (shadow_tens_q == 4'd0);
    // First cycle of each slot is dark so the previous digit cannot ghost.
    sel_en     = (ref_cnt_q != '0) && pwm_on && !tens_blank;
    digit_bad  = (digit1 > 4'd9) || (digit0 > 4'd9);

    ref_cnt_d     = ref_wrap ? '0 : ref_cnt_q + 1'b1;
    slot_d        = ref_wrap ? !slot_q : slot_q;
    pwm_cnt_d     = pwm_cnt_q + 1'b1;
    shadow_tens_d = frame_end ? digit1 : shadow_tens_q;
    shadow_ones_d = frame_end ? digit0 : shadow_ones_q;

    // A new error on the snapshot edge takes priority over a clear.
    if (frame_end && digit_bad) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end

    dig_en_d = DigInv;
    seg_d    = SegInv;
    if (sel_en) begin
      dig_en_d = (slot_q ? 2'b10 : 2'b01) ^ DigInv;
      seg_d    = seg_decode(cur_digit) ^ SegInv;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt_q     <= '0;
      slot_q        <= 1'b0;
      pwm_cnt_q     <= '0;
      shadow_tens_q <= 4'd0;
      shadow_ones_q <= 4'd0;
      err_q         <= 1'b0;
      seg_q         <= SegInv;
      dig_en_q      <= DigInv;
    end else begin
      ref_cnt_q     <= ref_cnt_d;
      slot_q        <= slot_d;
      pwm_cnt_q     <= pwm_cnt_d;
      shadow_tens_q <= shadow_tens_d;
      shadow_ones_q <= shadow_ones_d;
      err_q         <= err_d;
      seg_q         <= seg_d;
      dig_en_q      <= dig_en_d;
    end
  end

  assign seg    = seg_q;
  assign dig_en = dig_en_q;
  assign err    = err_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner. Three instances share the stimulus:
// REFRESH_DIV=4 active-high, REFRESH_DIV=4 active-low outputs, REFRESH_DIV=16.
// k counts rising edges since reset release; outputs after edge k reflect state s=k-1.
module tb_bcd_display_scanner;

  logic       clk;
  logic       rst;
  logic [3:0] digit1;
  logic [3:0] digit0;
  logic       blank_lz;
  logic [2:0] brightness;
  logic       err_clr;

  logic [6:0] seg4, seg_al, seg16;
  logic [1:0] dig4, dig_al, dig16;
  logic       err4, err_al, err16;

  int n_vec;
  int n_err;
  int k;

  bcd_display_scanner #(
    .REFRESH_DIV(4), .PWM_BITS(3), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst(rst), .digit1(digit1), .digit0(digit0), .blank_lz(blank_lz),
    .brightness(brightness), .err_clr(err_clr), .seg(seg4), .dig_en(dig4), .err(err4)
  );

  bcd_display_scanner #(
    .REFRESH_DIV(4), .PWM_BITS(3), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
  ) dut_al (
    .clk(clk), .rst(rst), .digit1(digit1), .digit0(digit0), .blank_lz(blank_lz),
    .brightness(brightness), .err_clr(err_clr), .seg(seg_al), .dig_en(dig_al),
    .err(err_al)
  );

  bcd_display_scanner #(
    .REFRESH_DIV(16), .PWM_BITS(3), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
  ) dut16 (
    .clk(clk), .rst(rst), .digit1(digit1), .digit0(digit0), .blank_lz(blank_lz),
    .brightness(brightness), .err_clr(err_clr), .seg(seg16), .dig_en(dig16),
    .err(err16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s at k=%0d: observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic run_to(input int target);
    while (k < target) tick();
  endtask

  task automatic chk_out(input string tag, input logic [1:0] d, input logic [6:0] s);
    chk({tag, "_dig"}, {6'd0, dig4}, {6'd0, d});
    chk({tag, "_seg"}, {1'b0, seg4}, {1'b0, s});
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    k          = 0;
    rst        = 1'b1;
    digit1     = 4'd4;
    digit0     = 4'd7;
    blank_lz   = 1'b0;
    brightness = 3'd7;
    err_clr    = 1'b0;

    // 1. reset
    tick(); tick(); tick();
    chk_out("rst", 2'b00, 7'h00);
    chk("rst_err", {7'd0, err4}, 8'd0);
    chk("rst_al_seg", {1'b0, seg_al}, 8'h7f);
    chk("rst_al_dig", {6'd0, dig_al}, 8'h03);
    rst = 1'b0;
    k   = 0;

    // First frame shows shadow 00
    run_to(1); chk_out("f0_guard", 2'b00, 7'h00);
    run_to(2); chk_out("f0_ones", 2'b01, 7'h3f);
    run_to(6); chk_out("f0_tens", 2'b10, 7'h3f);

    // 2. 47 captured at edge 8
    run_to(9); chk_out("t2_guard0", 2'b00, 7'h00);
    for (int i = 10; i <= 12; i++) begin
      run_to(i); chk_out("t2_ones", 2'b01, 7'h07);
    end
    run_to(10);
    chk("t2_al_seg", {1'b0, seg_al}, 8'h78);
    chk("t2_al_dig", {6'd0, dig_al}, 8'h02);
    run_to(13); chk_out("t2_guard1", 2'b00, 7'h00);
    for (int i = 14; i <= 16; i++) begin
      run_to(i); chk_out("t2_tens", 2'b10, 7'h66);
    end

    // 3. 05 with blanking, captured at edge 24
    digit1   = 4'd0;
    digit0   = 4'd5;
    blank_lz = 1'b1;
    run_to(22); chk_out("t3_old_tens", 2'b10, 7'h66);
    for (int i = 26; i <= 28; i++) begin
      run_to(i); chk_out("t3_ones", 2'b01, 7'h6d);
    end
    for (int i = 30; i <= 32; i++) begin
      run_to(i); chk_out("t3_blank", 2'b00, 7'h00);
    end
    blank_lz = 1'b0;
    run_to(34); chk_out("t3_ones2", 2'b01, 7'h6d);
    run_to(38); chk_out("t3_noblank", 2'b10, 7'h3f);
    run_to(40); chk_out("t3_noblank2", 2'b10, 7'h3f);

    // 4. invalid digit, captured at edge 48
    digit0 = 4'hb;
    run_to(47); chk("t4_err_pre", {7'd0, err4}, 8'd0);
    run_to(48); chk("t4_err_set", {7'd0, err4}, 8'd1);
    run_to(50); chk_out("t4_dash", 2'b01, 7'h40);
    run_to(52); chk_out("t4_dash2", 2'b01, 7'h40);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_err_clr", {7'd0, err4}, 8'd0);
    run_to(55); chk("t4_err_hold0", {7'd0, err4}, 8'd0);
    err_clr = 1'b1;
    tick();
    chk("t4_set_wins", {7'd0, err4}, 8'd1);

    // 5. clear err, then 3 captured at edge 64, 8 applied mid-frame
    digit0 = 4'd3;
    tick();
    err_clr = 1'b0;
    chk("t5_err_clr", {7'd0, err4}, 8'd0);
    run_to(58); chk_out("t5_old_dash", 2'b01, 7'h40);
    run_to(66); chk_out("t5_three", 2'b01, 7'h4f);
    run_to(67); chk_out("t5_three2", 2'b01, 7'h4f);
    digit0 = 4'd8;
    run_to(68); chk_out("t5_held", 2'b01, 7'h4f);
    run_to(72); chk_out("t5_tens", 2'b10, 7'h3f);
    chk("t5_err_valid", {7'd0, err4}, 8'd0);
    run_to(74); chk_out("t5_eight", 2'b01, 7'h7f);
    run_to(76); chk_out("t5_eight2", 2'b01, 7'h7f);

    // 6a. brightness 0: always dark
    brightness = 3'd0;
    for (int i = 0; i < 64; i++) begin
      tick();
      chk("t6_dark", {6'd0, dig4}, 8'd0);
    end

    // 6b. brightness 2 on the REFRESH_DIV=16 instance
    brightness = 3'd2;
    for (int i = 0; i < 64; i++) begin
      logic [1:0] exp_dig;
      int         s;
      tick();
      s       = k - 1;
      exp_dig = 2'b00;
      if ((s % 16) != 0 && (s % 8) < 2) exp_dig = ((s / 16) % 2 == 1) ? 2'b10 : 2'b01;
      chk("t6_pwm16", {6'd0, dig16}, {6'd0, exp_dig});
    end

    // Mid-frame reset with err set
    brightness = 3'd7;
    digit0     = 4'hc;
    run_to(209); chk("mr_err_set", {7'd0, err4}, 8'd1);
    run_to(211);
    rst = 1'b1;
    tick();
    chk_out("mr_rst", 2'b00, 7'h00);
    chk("mr_rst_err", {7'd0, err4}, 8'd0);
    chk("mr_al_seg", {1'b0, seg_al}, 8'h7f);
    rst = 1'b0;
    k   = 0;
    run_to(1); chk_out("mr_guard", 2'b00, 7'h00);
    run_to(2); chk_out("mr_zero", 2'b01, 7'h3f);
    chk("mr_err_low", {7'd0, err4}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
